// File: rtl/apb_gpio_arb_if.sv
// Bundle of requester-side and APB-side signals around the apb_gpio_arb sequencer.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface apb_gpio_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req,   m1_req;
  logic              m0_write, m1_write;
  logic [ADDR_W-1:0] m0_addr,  m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_gnt,   m1_gnt;
  logic              m0_done,  m1_done;
  logic              m0_err,   m1_err;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;

  logic              apb_psel, apb_penable, apb_pwrite;
  logic [ADDR_W-1:0] apb_paddr;
  logic [DATA_W-1:0] apb_pwdata;
  logic [DATA_W-1:0] apb_prdata;

  modport slave (
    input  m0_req, m1_req, m0_write, m1_write, m0_addr, m1_addr, m0_wdata, m1_wdata,
    output m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, m0_rdata, m1_rdata,
    output apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata,
    input  apb_prdata
  );

  modport master (
    output m0_req, m1_req, m0_write, m1_write, m0_addr, m1_addr, m0_wdata, m1_wdata,
    input  m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, m0_rdata, m1_rdata,
    input  apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata,
    output apb_prdata
  );
endinterface

// File: rtl/apb_gpio_arb.sv
// Two-port round-robin arbiter and APB master sequencer in front of apb_gpio.
// Holds the address for HOLD_CYC cycles after access because the slave has no pready.
module apb_gpio_arb #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int HOLD_CYC = 1
) (
  input  logic          apb_pclk,
  input  logic          apb_prstn,
  apb_gpio_arb_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_HOLD, S_DONE} state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              sel_q, sel_d;
  logic              err_pend_q, err_pend_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic              done0_q, done0_d, done1_q, done1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  // Request mux: on a tie the port not granted last wins.
  logic              any_req, pick, req_wr, req_legal;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata, result;

  assign any_req   = bus.m0_req | bus.m1_req;
  assign pick      = (bus.m0_req & bus.m1_req) ? ~last_q : bus.m1_req;
  assign req_wr    = pick ? bus.m1_write : bus.m0_write;
  assign req_addr  = pick ? bus.m1_addr  : bus.m0_addr;
  assign req_wdata = pick ? bus.m1_wdata : bus.m0_wdata;
  assign req_legal = req_wr ? (req_addr[7:0] == 8'h44 || req_addr[7:0] == 8'h54)
                            : (req_addr[7:0] == 8'h48 || req_addr[7:0] == 8'h58);
  assign result    = (err_pend_q | pwrite_q) ? '0 : bus.apb_prdata;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    last_d     = last_q;
    sel_d      = sel_q;
    err_pend_d = err_pend_q;
    cnt_d      = cnt_q;
    psel_d     = 1'b0;
    penable_d  = 1'b0;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    err0_d     = 1'b0;
    err1_d     = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;

    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          last_d     = pick;
          sel_d      = pick;
          gnt0_d     = ~pick;
          gnt1_d     = pick;
          err_pend_d = ~req_legal;
          if (req_legal) begin
            state_d  = S_SETUP;
            psel_d   = 1'b1;
            pwrite_d = req_wr;
            paddr_d  = req_addr;
            pwdata_d = req_wdata;
          end else begin
            state_d  = S_DONE;
          end
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end
      S_ACCESS: begin
        state_d = S_HOLD;
        cnt_d   = 4'(HOLD_CYC - 1);
      end
      S_HOLD: begin
        if (cnt_q == 4'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (sel_q) begin
          done1_d  = 1'b1;
          err1_d   = err_pend_q;
          rdata1_d = result;
        end else begin
          done0_d  = 1'b1;
          err0_d   = err_pend_q;
          rdata0_d = result;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge apb_pclk) begin
    if (!apb_prstn) begin
      state_q    <= S_IDLE;
      last_q     <= 1'b1;
      sel_q      <= 1'b0;
      err_pend_q <= 1'b0;
      cnt_q      <= 4'd0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      sel_q      <= sel_d;
      err_pend_q <= err_pend_d;
      cnt_q      <= cnt_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      err0_q     <= err0_d;
      err1_q     <= err1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign bus.m0_gnt      = gnt0_q;
  assign bus.m1_gnt      = gnt1_q;
  assign bus.m0_done     = done0_q;
  assign bus.m1_done     = done1_q;
  assign bus.m0_err      = err0_q;
  assign bus.m1_err      = err1_q;
  assign bus.m0_rdata    = rdata0_q;
  assign bus.m1_rdata    = rdata1_q;
  assign bus.apb_psel    = psel_q;
  assign bus.apb_penable = penable_q;
  assign bus.apb_pwrite  = pwrite_q;
  assign bus.apb_paddr   = paddr_q;
  assign bus.apb_pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_gpio_arb.sv
// Scoreboard bench for apb_gpio_arb: directed stimulus pushes expected grants, APB
// accesses and completions; monitors on the falling edge pop and compare.
module tb_apb_gpio_arb;

  localparam logic [31:0] GPIO_A_IN = 32'hCAFE_0048;
  localparam logic [31:0] GPIO_B_IN = 32'h1234_5678;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_gpio_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  apb_gpio_arb_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

  apb_gpio_arb #(.ADDR_W(32), .DATA_W(32), .HOLD_CYC(1)) u_dut (
    .apb_pclk (clk),
    .apb_prstn(rst_n),
    .bus      (bus)
  );

  apb_gpio_arb #(.ADDR_W(32), .DATA_W(32), .HOLD_CYC(3)) u_dut3 (
    .apb_pclk (clk),
    .apb_prstn(rst_n),
    .bus      (bus3)
  );

  // Minimal apb_gpio slave: read-only inputs at 0x48/0x58, output registers at 0x44/0x54.
  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    case (a[7:0])
      8'h48:   return GPIO_A_IN;
      8'h58:   return GPIO_B_IN;
      default: return 32'h0;
    endcase
  endfunction

  assign bus.apb_prdata  = slave_rd(bus.apb_paddr);
  assign bus3.apb_prdata = slave_rd(bus3.apb_paddr);

  logic [31:0] gpioa_o_r = '0;
  logic [31:0] gpiob_o_r = '0;
  always @(posedge clk) begin
    if (bus.apb_psel === 1'b1 && bus.apb_penable === 1'b1 && bus.apb_pwrite === 1'b1) begin
      if (bus.apb_paddr[7:0] == 8'h44)      gpioa_o_r <= bus.apb_pwdata;
      else if (bus.apb_paddr[7:0] == 8'h54) gpiob_o_r <= bus.apb_pwdata;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { logic port; int cyc; } gnt_t;
  typedef struct { logic port; logic err; logic [31:0] rdata; int cyc; } done_t;
  typedef struct { logic [31:0] addr; logic wr; logic [31:0] wdata; int cyc; } acc_t;
  typedef struct { logic port; logic wr; logic [31:0] addr; logic [31:0] wdata;
                   logic legal; logic [31:0] rdata; } vec_t;

  gnt_t  gnt_q[$];
  done_t done_q[$];
  acc_t  acc_q[$];
  int    e3_q[$];

  // Main monitor
  logic        prev_psel = 1'b0, prev_pen = 1'b0, hold_chk = 1'b0, post_rst = 1'b0;
  logic        hold_wr = 1'b0;
  logic [31:0] hold_addr = '0, hold_wdata = '0;
  logic [31:0] exp_rd [2] = '{32'h0, 32'h0};

  always @(negedge clk) begin
    gnt_t  g;
    done_t d;
    acc_t  a;
    if (post_rst && rst_n) begin
      check("post_reset_ctrl", {bus.apb_psel, bus.apb_penable, bus.m0_gnt, bus.m1_gnt,
                                bus.m0_done, bus.m1_done, bus.m0_err, bus.m1_err}, 64'h0);
      post_rst = 1'b0;
    end
    if (bus.m0_gnt === 1'b1 || bus.m1_gnt === 1'b1) begin
      if (gnt_q.size() == 0) check("unexpected_gnt", gnt_q.size(), 1);
      else begin
        g = gnt_q.pop_front();
        check("gnt_port", {bus.m1_gnt, bus.m0_gnt}, g.port ? 2'b10 : 2'b01);
        check("gnt_cycle", cyc, g.cyc);
      end
    end
    if (bus.apb_psel === 1'b1 && bus.apb_penable === 1'b1) begin
      if (acc_q.size() == 0) check("unexpected_access", acc_q.size(), 1);
      else begin
        a = acc_q.pop_front();
        check("acc_paddr", bus.apb_paddr, a.addr);
        check("acc_pwrite", bus.apb_pwrite, a.wr);
        check("acc_pwdata", bus.apb_pwdata, a.wdata);
        check("acc_cycle", cyc, a.cyc);
        check("setup_before_access", {prev_psel, prev_pen}, 2'b10);
      end
      hold_chk   = 1'b1;
      hold_addr  = bus.apb_paddr;
      hold_wr    = bus.apb_pwrite;
      hold_wdata = bus.apb_pwdata;
    end else if (hold_chk) begin
      check("hold_ctrl", {bus.apb_psel, bus.apb_penable, bus.apb_pwrite}, {2'b00, hold_wr});
      check("hold_paddr", bus.apb_paddr, hold_addr);
      check("hold_pwdata", bus.apb_pwdata, hold_wdata);
    end
    if (bus.m0_done === 1'b1 || bus.m1_done === 1'b1) begin
      hold_chk = 1'b0;
      if (done_q.size() == 0) check("unexpected_done", done_q.size(), 1);
      else begin
        d = done_q.pop_front();
        check("done_port", {bus.m1_done, bus.m0_done}, d.port ? 2'b10 : 2'b01);
        check("done_cycle", cyc, d.cyc);
        if (d.port) begin
          check("m1_err", bus.m1_err, d.err);
          check("m1_rdata", bus.m1_rdata, d.rdata);
          check("m0_err_quiet", bus.m0_err, 1'b0);
          check("m0_rdata_hold", bus.m0_rdata, exp_rd[0]);
          exp_rd[1] = d.rdata;
        end else begin
          check("m0_err", bus.m0_err, d.err);
          check("m0_rdata", bus.m0_rdata, d.rdata);
          check("m1_err_quiet", bus.m1_err, 1'b0);
          check("m1_rdata_hold", bus.m1_rdata, exp_rd[1]);
          exp_rd[0] = d.rdata;
        end
      end
    end
    if (!rst_n) begin
      hold_chk  = 1'b0;
      post_rst  = 1'b1;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
    end
    prev_psel = bus.apb_psel;
    prev_pen  = bus.apb_penable;
  end

  // HOLD_CYC = 3 monitor: window checks against the oldest outstanding read of 0x48
  always @(negedge clk) begin
    int c;
    if (e3_q.size() != 0 && rst_n) begin
      c = e3_q[0];
      if (cyc == c + 1) check("h3_gnt", {bus3.m1_gnt, bus3.m0_gnt}, 2'b01);
      if (cyc == c + 2) check("h3_access", {bus3.apb_psel, bus3.apb_penable}, 2'b11);
      if (cyc >= c + 2 && cyc <= c + 5) check("h3_paddr_hold", bus3.apb_paddr, 32'h48);
      if (cyc >= c + 3 && cyc <= c + 6) check("h3_psel_low", {bus3.apb_psel, bus3.apb_penable}, 2'b00);
    end
    if (bus3.m0_done === 1'b1 || bus3.m1_done === 1'b1) begin
      if (e3_q.size() == 0) check("h3_unexpected_done", e3_q.size(), 1);
      else begin
        c = e3_q.pop_front();
        check("h3_done_cycle", cyc, c + 7);
        check("h3_rdata", bus3.m0_rdata, GPIO_A_IN);
        check("h3_err_port", {bus3.m1_done, bus3.m0_err}, 2'b00);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input vec_t v);
    int c = cyc;
    if (v.port) begin
      bus.m1_req = 1'b1; bus.m1_write = v.wr; bus.m1_addr = v.addr; bus.m1_wdata = v.wdata;
    end else begin
      bus.m0_req = 1'b1; bus.m0_write = v.wr; bus.m0_addr = v.addr; bus.m0_wdata = v.wdata;
    end
    gnt_q.push_back('{port: v.port, cyc: c + 1});
    if (v.legal) begin
      acc_q.push_back('{addr: v.addr, wr: v.wr, wdata: v.wdata, cyc: c + 2});
      done_q.push_back('{port: v.port, err: 1'b0, rdata: v.rdata, cyc: c + 5});
    end else begin
      done_q.push_back('{port: v.port, err: 1'b1, rdata: 32'h0, cyc: c + 2});
    end
    tick(2);
    if (v.port) bus.m1_req = 1'b0;
    else        bus.m0_req = 1'b0;
    if (v.legal) tick(3);
  endtask

  vec_t vecs [8] = '{
    '{1'b0, 1'b1, 32'h0000_0044, 32'hA5A5_0001, 1'b1, 32'h0},
    '{1'b1, 1'b0, 32'h0000_0058, 32'h0,         1'b1, 32'h1234_5678},
    '{1'b0, 1'b0, 32'h0000_0048, 32'h0,         1'b1, 32'hCAFE_0048},
    '{1'b1, 1'b1, 32'h0000_0054, 32'h0BAD_F00D, 1'b1, 32'h0},
    '{1'b0, 1'b1, 32'h0000_0048, 32'h1111_2222, 1'b0, 32'h0},
    '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         1'b0, 32'h0},
    '{1'b0, 1'b0, 32'hFFFF_FF58, 32'h0,         1'b1, 32'h1234_5678},
    '{1'b1, 1'b0, 32'h0000_0044, 32'h0,         1'b0, 32'h0}
  };

  initial begin
    int c;
    bus.m0_req = 1'b0;  bus.m0_write = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0;  bus.m1_write = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
    bus3.m0_req = 1'b0; bus3.m0_write = 1'b0; bus3.m0_addr = '0; bus3.m0_wdata = '0;
    bus3.m1_req = 1'b0; bus3.m1_write = 1'b0; bus3.m1_addr = '0; bus3.m1_wdata = '0;

    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    check("rst_apb_ctrl", {bus.apb_pwrite, bus.apb_paddr}, 64'h0);
    check("rst_pwdata", bus.apb_pwdata, 32'h0);
    check("rst_rdata", {bus.m0_rdata, bus.m1_rdata}, 64'h0);
    check("rst_h3_ctrl", {bus3.apb_psel, bus3.apb_penable, bus3.m0_done, bus3.m0_gnt}, 4'h0);

    // Both ports held: grants alternate m0, m1, m0, m1, five cycles apart.
    c = cyc;
    bus.m0_req = 1'b1; bus.m0_write = 1'b0; bus.m0_addr = 32'h48;
    bus.m1_req = 1'b1; bus.m1_write = 1'b0; bus.m1_addr = 32'h58;
    for (int k = 0; k < 4; k++) begin
      gnt_q.push_back('{port: k[0], cyc: c + 1 + 5 * k});
      acc_q.push_back('{addr: k[0] ? 32'h58 : 32'h48, wr: 1'b0, wdata: 32'h0, cyc: c + 2 + 5 * k});
      done_q.push_back('{port: k[0], err: 1'b0, rdata: k[0] ? GPIO_B_IN : GPIO_A_IN,
                         cyc: c + 5 + 5 * k});
    end
    tick(16);
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    tick(5);

    foreach (vecs[i]) issue(vecs[i]);
    tick(2);
    check("slave_gpioa_o", gpioa_o_r, 32'hA5A5_0001);
    check("slave_gpiob_o", gpiob_o_r, 32'h0BAD_F00D);

    // Reset during ACCESS aborts the transfer without a done.
    c = cyc;
    bus.m0_req = 1'b1; bus.m0_write = 1'b1; bus.m0_addr = 32'h44; bus.m0_wdata = 32'h5555_AAAA;
    gnt_q.push_back('{port: 1'b0, cyc: c + 1});
    acc_q.push_back('{addr: 32'h44, wr: 1'b1, wdata: 32'h5555_AAAA, cyc: c + 2});
    tick(2);
    bus.m0_req = 1'b0;
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(3);
    issue('{1'b0, 1'b0, 32'h0000_0058, 32'h0, 1'b1, 32'h1234_5678});
    tick(1);

    // HOLD_CYC = 3 instance: read of 0x48.
    c = cyc;
    bus3.m0_req = 1'b1; bus3.m0_write = 1'b0; bus3.m0_addr = 32'h48;
    e3_q.push_back(c);
    tick(2);
    bus3.m0_req = 1'b0;
    tick(9);

    check("gnt_q_drained", gnt_q.size(), 0);
    check("acc_q_drained", acc_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);
    check("h3_q_drained", e3_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
